// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch queue.
// Optional feature macro: IFETCH_PERF_CNT_EN (performance counters in ifetch_queue).
package ifetch_pkg;

    // Default machine width and reset vector
    localparam int unsigned           XLEN_DEFAULT     = 32;
    localparam logic [XLEN_DEFAULT-1:0] RESET_PC_DEFAULT = '0;

    // Instructions are word aligned: the low INST_ALIGN_BITS of a PC are always zero
    localparam int unsigned             INST_ALIGN_BITS = 2;
    localparam logic [XLEN_DEFAULT-1:0] INST_ALIGN_MASK = 32'hFFFF_FFFC;

    // Canonical NOP (addi x0, x0, 0) for decode-side bubble insertion
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // One buffered fetch result
    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [XLEN_DEFAULT-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous prefetch FIFO: DEPTH entries (power of two) of WIDTH bits.
// clear (flush) has priority over push; head_data is the oldest entry.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter  int WIDTH   = 2 * XLEN_DEFAULT,
    parameter  int DEPTH   = 2,
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int COUNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               push,
    input  logic [WIDTH-1:0]   push_data,
    input  logic               pop,
    output logic [WIDTH-1:0]   head_data,
    output logic [COUNT_W-1:0] count,
    output logic               full,
    output logic               empty
);

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [COUNT_W-1:0] count_q;
    logic               do_push;
    logic               do_pop;

    assign full      = (count_q == COUNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    // A push into a full FIFO or a pop from an empty one is ignored
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + COUNT_W'(do_push) - COUNT_W'(do_pop);
        end
    end

    // Entry storage is pure data and carries no reset
    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction-fetch stage: PC sequencing, 1-cycle imem request/response,
// DEPTH-entry prefetch FIFO with valid/ready handoff, and redirect/flush.
// Optional macro IFETCH_PERF_CNT_EN adds perf_fetched/perf_redirects/perf_stalls.
module ifetch_queue
    import ifetch_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter int              DEPTH    = 2,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
    parameter int              CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic [XLEN-1:0]  imem_rdata,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_inst,
    output logic [XLEN-1:0]  out_pc,
    output logic             flush
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] perf_fetched,
    output logic [CNT_W-1:0] perf_redirects,
    output logic [CNT_W-1:0] perf_stalls
`endif
);

    localparam int FIFO_CNT_W = $clog2(DEPTH) + 1;
    localparam int OCC_W      = FIFO_CNT_W + 1;

    logic [XLEN-1:0]       pc_q;
    logic                  inflight_q;
    logic [XLEN-1:0]       inflight_pc_q;
    logic [XLEN-1:0]       redirect_target;
    logic [FIFO_CNT_W-1:0] fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [2*XLEN-1:0]     head_data;
    logic [OCC_W-1:0]      occupancy;
    logic                  pop;
    logic                  push;
    logic                  issue;
    logic                  unused_fifo_full;

    // Low address bits of a redirect target are forced to zero
    assign redirect_target = redirect_pc & ~((XLEN'(1) << INST_ALIGN_BITS) - XLEN'(1));

    assign pop  = out_valid & out_ready;
    assign push = inflight_q;

    // Entries that will be held after this edge if no new request goes out:
    // a slot is reserved for every request in flight, and a pop frees one now
    assign occupancy = {1'b0, fifo_count} + OCC_W'(inflight_q) - OCC_W'(pop);
    assign issue     = ~rst & ~redirect_valid & (occupancy < OCC_W'(DEPTH));

    assign imem_req  = issue;
    assign imem_addr = pc_q;
    assign flush     = redirect_valid;

    // Head is gated so outputs read zero whenever nothing valid is presented
    assign out_valid = ~fifo_empty;
    assign out_pc    = out_valid ? head_data[2*XLEN-1:XLEN] : '0;
    assign out_inst  = out_valid ? head_data[XLEN-1:0]      : '0;

    // Full flag is redundant here: the credit check already prevents overrun
    assign unused_fifo_full = fifo_full;

    // PC sequencing and in-flight flag: reset, then redirect, then normal issue
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
        end else if (redirect_valid) begin
            pc_q       <= redirect_target;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                pc_q <= pc_q + XLEN'(4);
            end
        end
    end

    // PC tag travelling with the outstanding request (data only, no reset)
    always_ff @(posedge clk) begin
        if (issue) begin
            inflight_pc_q <= pc_q;
        end
    end

    ifetch_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect_valid),
        .push      (push),
        .push_data ({inflight_pc_q, imem_rdata}),
        .pop       (pop),
        .head_data (head_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef IFETCH_PERF_CNT_EN
    // Event counters, wrapping at 2^CNT_W
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched   <= '0;
            perf_redirects <= '0;
            perf_stalls    <= '0;
        end else begin
            if (push) begin
                perf_fetched <= perf_fetched + CNT_W'(1);
            end
            if (redirect_valid) begin
                perf_redirects <= perf_redirects + CNT_W'(1);
            end
            if (out_valid && !out_ready) begin
                perf_stalls <= perf_stalls + CNT_W'(1);
            end
        end
    end
`else
    logic [CNT_W-1:0] unused_perf_width;
    assign unused_perf_width = '0;
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed timing scenarios plus a randomized run.
// Expected output stream is the architectural instruction sequence
// (consecutive PCs from the last reset/redirect target) held in a queue.
module tb_ifetch_queue;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam int          CNT_W    = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        flush;
`ifdef IFETCH_PERF_CNT_EN
    logic [CNT_W-1:0] perf_fetched;
    logic [CNT_W-1:0] perf_redirects;
    logic [CNT_W-1:0] perf_stalls;
`endif

    always #5 clk = ~clk;

    ifetch_queue #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC),
        .CNT_W    (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .flush          (flush)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_redirects (perf_redirects),
        .perf_stalls    (perf_stalls)
`endif
    );

    // Instruction memory contents: a distinct word per address
    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // 1-cycle-latency memory
    logic [31:0] last_addr;
    always @(posedge clk) last_addr <= imem_req ? imem_addr : 32'hBAD0_0000;
    assign imem_rdata = inst_of(last_addr);

    // Scoreboard state
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;
    exp_t        exp_q[$];
    logic [31:0] exp_tail;
    logic [31:0] exp_req_addr;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic topup();
        while (exp_q.size() < 8) begin
            exp_q.push_back('{pc: exp_tail, inst: inst_of(exp_tail)});
            exp_tail += 32'd4;
        end
    endtask

    task automatic retarget(input logic [31:0] tgt);
        exp_q.delete();
        exp_tail     = tgt;
        exp_req_addr = tgt;
        topup();
    endtask

    // One normal cycle of stimulus, inputs applied just after the rising edge
    task automatic cycle(input logic ready, input logic redir, input logic [31:0] tgt);
        @(posedge clk);
        #1;
        rst            = 1'b0;
        out_ready      = ready;
        redirect_valid = redir;
        redirect_pc    = tgt;
        if (redir) retarget(tgt & ~32'h3);
        topup();
    endtask

    // One reset cycle (optionally with a competing redirect, which must lose)
    task automatic reset_cycle(input logic redir);
        @(posedge clk);
        #1;
        rst            = 1'b1;
        out_ready      = 1'($urandom_range(0, 1));
        redirect_valid = redir;
        redirect_pc    = 32'h0000_0200;
        retarget(RESET_PC);
    endtask

    // Monitor: compares every accepted output and request against the model
    int   outstanding = 0;
    logic stall_prev  = 1'b0;
    logic [31:0] prev_pc, prev_inst;
`ifdef IFETCH_PERF_CNT_EN
    logic [CNT_W-1:0] m_fetched, m_redir, m_stall;
    logic perf_armed = 1'b0;
    logic prev_req   = 1'b0;
`endif

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            outstanding = 0;
            stall_prev  = 1'b0;
        end else begin
            check32("flush_eq_redirect", flush, redirect_valid);
            if (redirect_valid) check32("req_blocked_by_redirect", imem_req, 1'b0);
            if (imem_req) begin
                check32("imem_addr_seq", imem_addr, exp_req_addr);
                exp_req_addr += 32'd4;
            end
            if (stall_prev) begin
                check32("stall_hold_valid", out_valid, 1'b1);
                check32("stall_hold_pc", out_pc, prev_pc);
                check32("stall_hold_inst", out_inst, prev_inst);
            end
            if (out_valid && out_ready && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    check32("stream_underflow", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check32("out_pc", out_pc, e.pc);
                    check32("out_inst", out_inst, e.inst);
                end
            end
            if (redirect_valid) outstanding = 0;
            else outstanding = outstanding + int'(imem_req) - int'(out_valid && out_ready);
            check32("no_overrun", 32'(outstanding <= DEPTH), 32'd1);
            stall_prev = out_valid && !out_ready && !redirect_valid;
            prev_pc    = out_pc;
            prev_inst  = out_inst;
        end
`ifdef IFETCH_PERF_CNT_EN
        if (perf_armed) begin
            check32("perf_fetched", perf_fetched, m_fetched);
            check32("perf_redirects", perf_redirects, m_redir);
            check32("perf_stalls", perf_stalls, m_stall);
        end
        if (rst) begin
            m_fetched  = '0;
            m_redir    = '0;
            m_stall    = '0;
            perf_armed = 1'b1;
        end else begin
            m_fetched += CNT_W'(prev_req);
            m_redir   += CNT_W'(redirect_valid);
            m_stall   += CNT_W'(out_valid && !out_ready);
        end
        prev_req = imem_req && !rst;
`endif
    end

    // Driver and directed timing checks
    initial begin
        int nreq;
        rst = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        exp_tail = RESET_PC; exp_req_addr = RESET_PC;

        // Reset state and first-fetch latency
        reset_cycle(1'b0);
        reset_cycle(1'b0);
        @(negedge clk);
        check32("rst_imem_req", imem_req, 1'b0);
        check32("rst_out_valid", out_valid, 1'b0);
        check32("rst_out_pc", out_pc, 32'h0);
        check32("rst_out_inst", out_inst, 32'h0);
        cycle(1'b1, 1'b0, 32'h0); @(negedge clk);
        check32("c0_req", imem_req, 1'b1);
        check32("c0_addr", imem_addr, 32'h0);
        cycle(1'b1, 1'b0, 32'h0); @(negedge clk);
        check32("c1_addr", imem_addr, 32'h4);
        check32("c1_valid", out_valid, 1'b0);
        cycle(1'b1, 1'b0, 32'h0); @(negedge clk);
        check32("c2_valid", out_valid, 1'b1);
        check32("c2_pc", out_pc, 32'h0);
        cycle(1'b1, 1'b0, 32'h0); @(negedge clk);
        check32("c3_pc", out_pc, 32'h4);
        repeat (4) cycle(1'b1, 1'b0, 32'h0);

        // Backpressure from reset: only DEPTH requests, then resume on first pop
        reset_cycle(1'b0);
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0, 32'h0); @(negedge clk);
            nreq += int'(imem_req);
        end
        check32("stall_issue_count", 32'(nreq), 32'(DEPTH));
        check32("stall_req_low", imem_req, 1'b0);
        check32("stall_head_pc", out_pc, 32'h0);
        cycle(1'b1, 1'b0, 32'h0); @(negedge clk);
        check32("resume_issue_same_cycle", imem_req, 1'b1);
        repeat (6) cycle(1'b1, 1'b0, 32'h0);

        // Redirect to misaligned target while the FIFO is full
        repeat (3) cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 32'h0000_0103); @(negedge clk);
        check32("redir_flush", flush, 1'b1);
        check32("redir_req", imem_req, 1'b0);
        cycle(1'b1, 1'b0, 32'h0); @(negedge clk);
        check32("redir_n1_req", imem_req, 1'b1);
        check32("redir_n1_addr", imem_addr, 32'h0000_0100);
        cycle(1'b1, 1'b0, 32'h0); @(negedge clk);
        check32("redir_n2_valid", out_valid, 1'b0);
        cycle(1'b1, 1'b0, 32'h0); @(negedge clk);
        check32("redir_n3_valid", out_valid, 1'b1);
        check32("redir_n3_pc", out_pc, 32'h0000_0100);
        check32("redir_n3_inst", out_inst, inst_of(32'h0000_0100));
        repeat (4) cycle(1'b1, 1'b0, 32'h0);

        // Back-to-back redirects: only the second target is delivered
        cycle(1'b1, 1'b1, 32'h0000_0040);
        cycle(1'b1, 1'b1, 32'h0000_0080); @(negedge clk);
        check32("b2b_req", imem_req, 1'b0);
        cycle(1'b1, 1'b0, 32'h0); @(negedge clk);
        check32("b2b_addr", imem_addr, 32'h0000_0080);
        cycle(1'b1, 1'b0, 32'h0); @(negedge clk);
        check32("b2b_valid_early", out_valid, 1'b0);
        cycle(1'b1, 1'b0, 32'h0); @(negedge clk);
        check32("b2b_pc", out_pc, 32'h0000_0080);
        repeat (3) cycle(1'b1, 1'b0, 32'h0);

        // PC wrap at the top of the address space
        cycle(1'b1, 1'b1, 32'hFFFF_FFFC);
        cycle(1'b1, 1'b0, 32'h0); @(negedge clk);
        check32("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        cycle(1'b1, 1'b0, 32'h0); @(negedge clk);
        check32("wrap_addr1", imem_addr, 32'h0);
        cycle(1'b1, 1'b0, 32'h0); @(negedge clk);
        check32("wrap_pc0", out_pc, 32'hFFFF_FFFC);
        cycle(1'b1, 1'b0, 32'h0); @(negedge clk);
        check32("wrap_pc1", out_pc, 32'h0);

`ifdef IFETCH_PERF_CNT_EN
        // 20 cycles with 3 stall cycles and one redirect
        reset_cycle(1'b0);
        for (int c = 0; c < 20; c++) begin
            cycle(!(c >= 8 && c <= 10), c == 11, 32'h0000_0300);
        end
        cycle(1'b1, 1'b0, 32'h0); @(negedge clk);
        check32("perf20_fetched", perf_fetched, 32'd15);
        check32("perf20_redirects", perf_redirects, 32'd1);
        check32("perf20_stalls", perf_stalls, 32'd3);
        reset_cycle(1'b0);
        cycle(1'b1, 1'b0, 32'h0); @(negedge clk);
        check32("perf_rst_fetched", perf_fetched, 32'd0);
        check32("perf_rst_redirects", perf_redirects, 32'd0);
        check32("perf_rst_stalls", perf_stalls, 32'd0);
        check32("perf_rst_valid", out_valid, 1'b0);
`endif

        // Randomized traffic: backpressure, redirects, occasional reset
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 199) == 0) reset_cycle(1'($urandom_range(0, 1)));
            else cycle(1'($urandom_range(0, 99) < 70), 1'($urandom_range(0, 99) < 6), $urandom);
        end

        // Reset beats a simultaneous redirect
        reset_cycle(1'b1); @(negedge clk);
        check32("rst_wins_req", imem_req, 1'b0);
        cycle(1'b1, 1'b0, 32'h0); @(negedge clk);
        check32("rst_wins_valid", out_valid, 1'b0);
        check32("rst_wins_addr", imem_addr, RESET_PC);
        repeat (6) cycle(1'b1, 1'b0, 32'h0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
